// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the CPU/IOP system-memory arbiter.
// Bus fields use big-endian bit numbering: bit 0 of data/write enables is the MS byte.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_IOP  = 2'd2
  } owner_e;

  // last_owner is a single bit: which requester most recently took the bus
  localparam logic LAST_CPU = 1'b0;
  localparam logic LAST_IOP = 1'b1;

  localparam int ADDR_MSB      = 15;
  localparam int ADDR_LSB_DFLT = 31;
  localparam int DATA_W        = 32;
  localparam int BE_W          = 4;

  // The hold counter saturates at MAX_HOLD-1, so it never needs to reach MAX_HOLD itself
  function automatic int hold_cnt_w(input int max_hold);
    return (max_hold > 1) ? $clog2(max_hold) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Next-owner decision for the memory arbiter: ownership is sticky while requested,
// ties go to the side that did not own last, and a long-held bus is preempted.
module mem_arb_select
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = hold_cnt_w(MAX_HOLD)
) (
  input  owner_e           owner_i,
  input  logic             last_owner_i,
  input  logic [CNT_W-1:0] hold_cnt_i,
  input  logic             cpu_req_i,
  input  logic             iop_req_i,
  output owner_e           next_owner_o,
  output logic             preempt_o
);

  localparam bit               PREEMPT_EN = (MAX_HOLD > 0);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  logic owner_req;
  logic other_req;

  always_comb begin
    owner_req = 1'b0;
    other_req = 1'b0;
    case (owner_i)
      OWN_CPU: begin
        owner_req = cpu_req_i;
        other_req = iop_req_i;
      end
      OWN_IOP: begin
        owner_req = iop_req_i;
        other_req = cpu_req_i;
      end
      default: ;
    endcase
  end

  assign preempt_o = PREEMPT_EN && (owner_i != OWN_NONE) &&
                     (hold_cnt_i == HOLD_LAST) && other_req;

  // On preemption both sides are requesting and last_owner is the current owner,
  // so the tie-break below hands the bus to the other side without a special case.
  always_comb begin
    next_owner_o = OWN_NONE;
    if ((owner_i != OWN_NONE) && owner_req && !preempt_o) begin
      next_owner_o = owner_i;
    end else if (cpu_req_i && iop_req_i) begin
      next_owner_o = (last_owner_i == LAST_CPU) ? OWN_IOP : OWN_CPU;
    end else if (cpu_req_i) begin
      next_owner_o = OWN_CPU;
    end else if (iop_req_i) begin
      next_owner_o = OWN_IOP;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single synchronous-read system memory between the CPU and the IOP.
// Registered ownership drives the bus mux; rvalid strobes follow the one-cycle read latency.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int ADDR_LSB = ADDR_LSB_DFLT
) (
  input  logic                       clock,
  input  logic                       reset,

  input  logic                       cpu_req,
  input  logic [ADDR_MSB:ADDR_LSB]   cpu_address,
  input  logic [0:BE_W-1]            cpu_write_en,
  input  logic [0:DATA_W-1]          cpu_data,
  output logic                       cpu_grant,
  output logic                       cpu_rvalid,

  input  logic                       iop_req,
  input  logic [ADDR_MSB:ADDR_LSB]   iop_address,
  input  logic [0:BE_W-1]            iop_write_en,
  input  logic [0:DATA_W-1]          iop_data,
  output logic                       iop_grant,
  output logic                       iop_rvalid,

  output logic [ADDR_MSB:ADDR_LSB]   mem_address,
  output logic [0:BE_W-1]            mem_write_en,
  output logic [0:DATA_W-1]          mem_wdata,
  input  logic [0:DATA_W-1]          mem_rdata
);

  localparam int               CNT_W     = hold_cnt_w(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  owner_e           owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             cpu_rvalid_q, cpu_rvalid_d;
  logic             iop_rvalid_q, iop_rvalid_d;
  logic             preempt;

  // Read data goes straight from memory to both requesters; only the strobes come from here.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;

  mem_arb_select #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_select (
    .owner_i      (owner_q),
    .last_owner_i (last_owner_q),
    .hold_cnt_i   (hold_cnt_q),
    .cpu_req_i    (cpu_req),
    .iop_req_i    (iop_req),
    .next_owner_o (owner_d),
    .preempt_o    (preempt)
  );

  // Saturating at MAX_HOLD-1 keeps preemption armed however long the owner has held.
  always_comb begin
    last_owner_d = last_owner_q;
    hold_cnt_d   = '0;
    if (owner_d == OWN_CPU) begin
      last_owner_d = LAST_CPU;
    end else if (owner_d == OWN_IOP) begin
      last_owner_d = LAST_IOP;
    end
    if ((owner_d == owner_q) && (owner_q != OWN_NONE)) begin
      hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
    end
  end

  assign cpu_rvalid_d = (owner_q == OWN_CPU) && cpu_req && (cpu_write_en == '0);
  assign iop_rvalid_d = (owner_q == OWN_IOP) && iop_req && (iop_write_en == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q      <= OWN_NONE;
      last_owner_q <= LAST_IOP;
      hold_cnt_q   <= '0;
      cpu_rvalid_q <= 1'b0;
      iop_rvalid_q <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      iop_rvalid_q <= iop_rvalid_d;
    end
  end

  // Write enables are gated by both ownership and the owner's live request,
  // so a release cycle or a reset mid-write never touches memory.
  always_comb begin
    mem_address  = '0;
    mem_wdata    = '0;
    mem_write_en = '0;
    case (owner_q)
      OWN_CPU: begin
        mem_address  = cpu_address;
        mem_wdata    = cpu_data;
        mem_write_en = cpu_req ? cpu_write_en : '0;
      end
      OWN_IOP: begin
        mem_address  = iop_address;
        mem_wdata    = iop_data;
        mem_write_en = iop_req ? iop_write_en : '0;
      end
      default: ;
    endcase
  end

  assign cpu_grant  = (owner_q == OWN_CPU);
  assign iop_grant  = (owner_q == OWN_IOP);
  assign cpu_rvalid = cpu_rvalid_q;
  assign iop_rvalid = iop_rvalid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus queues per-cycle expectations
// and read results; a negedge monitor pops and compares them against the DUT.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, iop_req = 1'b0;
  logic [15:31] cpu_address = '0, iop_address = '0;
  logic [0:3]  cpu_write_en = '0, iop_write_en = '0;
  logic [0:31] cpu_data = '0, iop_data = '0;
  logic [0:31] mem_rdata;

  logic        cpu_grant, iop_grant, cpu_rvalid, iop_rvalid;
  logic [15:31] mem_address;
  logic [0:3]  mem_write_en;
  logic [0:31] mem_wdata;

  logic        d0_cpu_grant, d0_iop_grant, d0_cpu_rvalid, d0_iop_rvalid;
  logic [15:31] d0_mem_address;
  logic [0:3]  d0_mem_write_en;
  logic [0:31] d0_mem_wdata;

  always #5 clock = ~clock;

  mem_arbiter #(.MAX_HOLD(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_write_en(cpu_write_en), .cpu_data(cpu_data),
    .cpu_grant(cpu_grant), .cpu_rvalid(cpu_rvalid),
    .iop_req(iop_req), .iop_address(iop_address), .iop_write_en(iop_write_en), .iop_data(iop_data),
    .iop_grant(iop_grant), .iop_rvalid(iop_rvalid),
    .mem_address(mem_address), .mem_write_en(mem_write_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Same stimulus with preemption disabled
  mem_arbiter #(.MAX_HOLD(0)) dut0 (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_write_en(cpu_write_en), .cpu_data(cpu_data),
    .cpu_grant(d0_cpu_grant), .cpu_rvalid(d0_cpu_rvalid),
    .iop_req(iop_req), .iop_address(iop_address), .iop_write_en(iop_write_en), .iop_data(iop_data),
    .iop_grant(d0_iop_grant), .iop_rvalid(d0_iop_rvalid),
    .mem_address(d0_mem_address), .mem_write_en(d0_mem_write_en), .mem_wdata(d0_mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous-read memory model, read-before-write, byte 0 = MS byte
  logic [0:31] mem [0:255];
  bit          mem_loaded = 1'b0;
  always @(posedge clock) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[8'h20] <= 32'h12345678;
      mem[8'h21] <= 32'h11223344;
      mem_loaded <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_write_en[b]) mem[mem_address[24:31]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
    mem_rdata <= mem[mem_address[24:31]];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         alt;
    logic [3:0] flags;   // {cpu_grant, iop_grant, cpu_rvalid, iop_rvalid}
    logic [0:3] we;
    string      name;
  } exp_t;
  typedef struct {
    bit          iop;
    logic [0:31] data;
    string       name;
  } rd_t;

  exp_t exp_q[$];
  rd_t  rd_q[$];
  int   checks = 0;
  int   passes = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
  endfunction

  task automatic exp_at(input int dc, input bit alt, input logic [3:0] flags,
                        input logic [0:3] we, input string name);
    exp_q.push_back('{cyc + dc, alt, flags, we, name});
  endtask

  task automatic exp_rd(input bit iop, input logic [0:31] data, input string name);
    rd_q.push_back('{iop, data, name});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic [15:31] a, input logic [0:3] we, input logic [0:31] d);
    cpu_req = req; cpu_address = a; cpu_write_en = we; cpu_data = d;
  endtask

  task automatic set_iop(input logic req, input logic [15:31] a, input logic [0:3] we, input logic [0:31] d);
    iop_req = req; iop_address = a; iop_write_en = we; iop_data = d;
  endtask

  always @(negedge clock) begin : monitor
    logic [3:0] act_flags;
    logic [0:3] act_we;
    rd_t        r;
    int         k;
    k = 0;
    while (k < exp_q.size()) begin
      if (exp_q[k].cyc <= cyc) begin
        act_flags = exp_q[k].alt ? {d0_cpu_grant, d0_iop_grant, d0_cpu_rvalid, d0_iop_rvalid}
                                 : {cpu_grant, iop_grant, cpu_rvalid, iop_rvalid};
        act_we    = exp_q[k].alt ? d0_mem_write_en : mem_write_en;
        if (exp_q[k].cyc < cyc) check({exp_q[k].name, "_missed"}, 64'(cyc), 64'(exp_q[k].cyc));
        else check(exp_q[k].name, {56'd0, act_flags, act_we}, {56'd0, exp_q[k].flags, exp_q[k].we});
        exp_q.delete(k);
      end else begin
        k++;
      end
    end
    if (cpu_rvalid || iop_rvalid) begin
      if (rd_q.size() == 0) begin
        check("unexpected_rvalid", {62'd0, cpu_rvalid, iop_rvalid}, 64'd0);
      end else begin
        r = rd_q.pop_front();
        check({r.name, "_who"}, {62'd0, cpu_rvalid, iop_rvalid}, r.iop ? 64'd1 : 64'd2);
        check(r.name, {32'd0, mem_rdata}, {32'd0, r.data});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then idle; a request during reset must not be granted
    #2 reset = 1'b1;
    tick(4);
    cpu_req = 1'b1;
    exp_at(0, 0, 4'b0000, 4'b0000, "reset_hold");
    tick(1);
    cpu_req = 1'b0;
    #44 reset = 1'b0;
    tick(1);
    for (int i = 0; i < 10; i++) exp_at(i, 0, 4'b0000, 4'b0000, "idle_after_reset");
    tick(10);

    // CPU read of 0x20
    set_cpu(1'b1, 17'h20, 4'b0000, 32'h0);
    exp_at(0, 0, 4'b0000, 4'b0000, "cpu_rd_req");
    exp_at(1, 0, 4'b1000, 4'b0000, "cpu_rd_grant");
    exp_at(2, 0, 4'b1010, 4'b0000, "cpu_rd_rvalid");
    exp_at(3, 0, 4'b0000, 4'b0000, "cpu_rd_done");
    exp_rd(1'b0, 32'h12345678, "cpu_rd_data");
    tick(2);
    cpu_req = 1'b0;
    tick(2);

    // Reset again so last_owner returns to IOP
    reset = 1'b1;
    exp_at(0, 0, 4'b0000, 4'b0000, "reset2_async");
    tick(2);
    reset = 1'b0;

    // Simultaneous first request: CPU first, direct handover to IOP
    set_cpu(1'b1, 17'h20, 4'b0000, 32'h0);
    set_iop(1'b1, 17'h21, 4'b0000, 32'h0);
    exp_at(0, 0, 4'b0000, 4'b0000, "tie_req");
    exp_at(1, 0, 4'b1000, 4'b0000, "tie_cpu_first");
    exp_at(2, 0, 4'b1010, 4'b0000, "tie_cpu_release");
    exp_at(3, 0, 4'b0100, 4'b0000, "tie_handover_iop");
    exp_at(4, 0, 4'b0101, 4'b0000, "tie_iop_rvalid");
    exp_at(5, 0, 4'b0000, 4'b0000, "tie_done");
    exp_rd(1'b0, 32'h12345678, "tie_cpu_data");
    exp_rd(1'b1, 32'h11223344, "tie_iop_data");
    tick(2);
    cpu_req = 1'b0;
    tick(2);
    iop_req = 1'b0;
    tick(2);

    // Preemption after 4 held cycles; MAX_HOLD=0 instance keeps the CPU on the bus
    set_cpu(1'b1, 17'h20, 4'b0000, 32'h0);
    exp_at(0, 0, 4'b0000, 4'b0000, "pre_req");
    exp_at(1, 0, 4'b1000, 4'b0000, "pre_cpu_c1");
    exp_at(2, 0, 4'b1010, 4'b0000, "pre_cpu_c2");
    exp_at(3, 0, 4'b1010, 4'b0000, "pre_cpu_c3");
    exp_at(4, 0, 4'b1010, 4'b0000, "pre_cpu_c4");
    exp_at(5, 0, 4'b0110, 4'b0000, "pre_iop_takes");
    exp_at(6, 0, 4'b0101, 4'b0000, "pre_iop_c2");
    exp_at(7, 0, 4'b0101, 4'b0000, "pre_iop_c3");
    exp_at(8, 0, 4'b0101, 4'b0000, "pre_iop_release");
    exp_at(9, 0, 4'b0000, 4'b0000, "pre_done");
    exp_at(1, 1, 4'b1000, 4'b0000, "nopre_cpu_c1");
    for (int i = 2; i <= 8; i++) exp_at(i, 1, 4'b1010, 4'b0000, "nopre_cpu_keeps");
    exp_at(9, 1, 4'b0000, 4'b0000, "nopre_done");
    for (int i = 0; i < 4; i++) exp_rd(1'b0, 32'h12345678, "pre_cpu_data");
    for (int i = 0; i < 3; i++) exp_rd(1'b1, 32'h11223344, "pre_iop_data");
    tick(2);
    set_iop(1'b1, 17'h21, 4'b0000, 32'h0);
    tick(6);
    cpu_req = 1'b0;
    iop_req = 1'b0;
    tick(2);

    // IOP byte write while an ungranted CPU write is pending
    set_iop(1'b1, 17'h21, 4'b1000, 32'hAB000000);
    exp_at(0, 0, 4'b0000, 4'b0000, "bw_req");
    exp_at(1, 0, 4'b0100, 4'b1000, "bw_iop_write");
    exp_at(2, 0, 4'b0100, 4'b0000, "bw_iop_release");
    exp_at(3, 0, 4'b1000, 4'b0000, "bw_cpu_gated");
    tick(1);
    set_cpu(1'b1, 17'h21, 4'b1111, 32'hFFFFFFFF);
    tick(1);
    iop_req = 1'b0;
    tick(1);
    cpu_req = 1'b0;
    tick(1);
    set_cpu(1'b1, 17'h21, 4'b0000, 32'h0);
    exp_at(0, 0, 4'b0000, 4'b0000, "bw_rb_req");
    exp_at(1, 0, 4'b1000, 4'b0000, "bw_rb_grant");
    exp_at(2, 0, 4'b1010, 4'b0000, "bw_rb_rvalid");
    exp_at(3, 0, 4'b0000, 4'b0000, "bw_rb_done");
    exp_rd(1'b0, 32'hAB223344, "bw_byte0_only");
    tick(2);
    cpu_req = 1'b0;
    tick(2);

    // Reset during an IOP-granted write, then a tie goes to the CPU
    set_iop(1'b1, 17'h20, 4'b1111, 32'hDEADBEEF);
    exp_at(0, 0, 4'b0000, 4'b0000, "rw_req");
    exp_at(1, 0, 4'b0000, 4'b0000, "rw_reset_kills_write");
    tick(1);
    #1 reset = 1'b1;
    tick(1);
    reset = 1'b0;
    set_cpu(1'b1, 17'h20, 4'b0000, 32'h0);
    set_iop(1'b1, 17'h21, 4'b0000, 32'h0);
    exp_at(0, 0, 4'b0000, 4'b0000, "rw_release_idle");
    exp_at(1, 0, 4'b1000, 4'b0000, "rw_tie_cpu");
    exp_at(2, 0, 4'b1010, 4'b0000, "rw_cpu_release");
    exp_at(3, 0, 4'b0100, 4'b0000, "rw_iop");
    exp_at(4, 0, 4'b0101, 4'b0000, "rw_iop_rvalid");
    exp_at(5, 0, 4'b0000, 4'b0000, "rw_done");
    exp_rd(1'b0, 32'h12345678, "rw_no_write_leak");
    exp_rd(1'b1, 32'hAB223344, "rw_iop_data");
    tick(2);
    cpu_req = 1'b0;
    tick(2);
    iop_req = 1'b0;
    tick(3);

    check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    check("rd_queue_drained", 64'(rd_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single synchronous-read system memory between the CPU and the IOP.
- Replaces the ad-hoc cpu_active handoff that the test bench currently drives from writes to 0x20/0x21.
- Grants are registered. A requester keeps ownership while it holds its request. Ties are resolved round-robin, with optional forced preemption after MAX_HOLD cycles.
- Generates per-requester read-data-valid strobes aligned to the memory's one-cycle read latency.

Parameters:
- MAX_HOLD, 16: maximum consecutive owned cycles before the owner is preempted when the other side is requesting. 0 disables preemption.
- ADDR_LSB, 31: last address bit index. The address field is [15:ADDR_LSB], giving a 17-bit word address.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- cpu_req  in  1  CPU requests the bus
- cpu_address  in  [15:31]  CPU word address
- cpu_write_en  in  [0:3]  CPU byte write enables; bit 0 is the MS byte
- cpu_data  in  [0:31]  CPU write data
- cpu_grant  out  1  CPU owns the bus this cycle
- cpu_rvalid  out  1  mem_rdata holds the CPU's read result this cycle
- iop_req, iop_address, iop_write_en, iop_data  in  same widths as the CPU signals  IOP request
- iop_grant  out  1  IOP owns the bus this cycle
- iop_rvalid  out  1  mem_rdata holds the IOP's read result this cycle
- mem_address  out  [15:31]  to memory
- mem_write_en  out  [0:3]  to memory
- mem_wdata  out  [0:31]  to memory
- mem_rdata  in  [0:31]  from memory; shared with both requesters externally

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clock.
- State: owner ∈ {NONE, CPU, IOP}, registered. Also last_owner (1 bit), hold_cnt (counter sized to MAX_HOLD), cpu_rvalid and iop_rvalid, all registered.
- Reset values:
  - owner=NONE, last_owner=IOP (so the CPU wins the first tie), hold_cnt=0.
  - All grants and rvalids 0.
  - mem_write_en=0.
- Reset mid-operation aborts immediately. A write in flight during the reset cycle is suppressed because write_en is gated by owner.
- Output mux (combinational from owner):
  - owner=X: mem_address=X_address; mem_wdata=X_data; mem_write_en=X_write_en when X_req=1, else 0.
  - owner=NONE: address 0, wdata 0, write_en 0.
  - X_grant = (owner==X).
- Next-owner rule, evaluated every edge:
  - If the owner is X, X_req=1, and no preemption is due: stay X.
  - Otherwise, if only one side requests: that side.
  - If both request: the side that is not last_owner.
  - If neither requests: NONE.
- Preemption:
  - Due when MAX_HOLD>0, hold_cnt==MAX_HOLD-1, and the other side requests.
  - On that edge, ownership passes to the other side.
- Counters and history:
  - hold_cnt increments each edge on which the owner is unchanged and not NONE. It resets to 0 on any owner change.
  - last_owner updates whenever a new non-NONE owner is taken.
- Latency:
  - Request to grant: 1 cycle. Handover CPU→IOP or IOP→CPU is direct, with no NONE gap.
  - Write: committed at the rising edge that ends a granted cycle with write_en≠0.
  - Read: X_rvalid=1 in the cycle after a granted cycle with X_req=1 and X_write_en==0, even if ownership has since changed. At most one rvalid is high per cycle.
- A requester must hold its address and data stable while X_req=1 and not granted.
- A granted cycle with X_req=0 (release cycle) performs no memory access.

Decomposition:
- Shared package:
  - Owner encoding constants: OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_IOP=2'd2.
  - Bus width constants: ADDR [15:31], DATA [0:31], BE [0:3].
- One natural sub-module, mem_arb_select: the combinational next-owner and preemption logic. It takes owner, last_owner, hold_cnt and both reqs, and returns next_owner.
- Registers and the output mux stay in mem_arbiter.

Test Plan:
- Reset then idle: assert reset 90 ns → grants 0, mem_write_en=0, both rvalids 0 for 10 cycles.
- CPU read: cpu_req=1, address 17'h20, write_en 0, memory word 0x12345678.
  - Expect cpu_grant in cycle 1.
  - Expect cpu_rvalid in cycle 2 with mem_rdata=0x12345678.
  - iop_grant stays 0 throughout.
- Simultaneous first request: both req rise on the same edge → CPU granted first (last_owner=IOP at reset). On CPU release, IOP is granted on the very next edge with no NONE cycle.
- Preemption, MAX_HOLD=4: CPU holds req continuously; IOP raises req at cycle 2.
  - CPU is granted for exactly 4 consecutive cycles, then IOP.
  - With MAX_HOLD=0 the CPU keeps the bus indefinitely.
- Byte write and gating: IOP writes address 17'h21, write_en 4'b1000, data 0xAB000000 while cpu_req is also 1 but ungranted.
  - Only byte 0 changes.
  - A CPU write attempted while ungranted never reaches mem_write_en.
- Reset mid-write: assert reset during an IOP-granted write cycle.
  - mem_write_en drops asynchronously; no memory change.
  - After release, the CPU wins a subsequent tie.
